// File: rtl/poly_eval_pkg.sv
// Shared definitions for the polynomial evaluation engine: FSM states,
// ALU operations, default width and field positions in the packed operand bus.
package poly_eval_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Field index within the packed {a, b, c, x} bus, in units of WIDTH bits
    localparam int FIELD_X = 0;
    localparam int FIELD_C = 1;
    localparam int FIELD_B = 2;
    localparam int FIELD_A = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        ADD1 = 3'd2,
        MUL2 = 3'd3,
        ADD2 = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_MUL = 1'b1
    } alu_op_t;

endpackage

// File: rtl/poly_alu.sv
// Combinational add/multiply unit; results wrap modulo 2^WIDTH.
module poly_alu
    import poly_eval_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = opa + opb;
        if (op == ALU_MUL) begin
            y = opa * opb;
        end
    end

endmodule

// File: rtl/poly_eval_arbiter.sv
// Two-requester round-robin front end sharing one ALU that evaluates
// a*x^2 + b*x + c by Horner's method, one ALU operation per cycle.
module poly_eval_arbiter
    import poly_eval_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [4*WIDTH-1:0] opnd0,
    input  logic [4*WIDTH-1:0] opnd1,
    output logic [1:0]         grant,
    output logic               busy,
    output logic [1:0]         done,
    output logic [WIDTH-1:0]   result
);

    state_t             state_reg, state_next;
    logic [1:0]         grant_reg;
    logic               ptr_reg;
    logic [WIDTH-1:0]   a_reg, b_reg, c_reg, x_reg;
    logic [WIDTH-1:0]   acc_reg, result_reg;

    logic               win_idx;
    logic [1:0]         win_onehot;
    logic [4*WIDTH-1:0] opnd_sel;
    alu_op_t            alu_op;
    logic [WIDTH-1:0]   alu_a, alu_b, alu_y;

    // Contention goes to the pointer; a lone request always wins
    always_comb begin
        win_idx = req[1];
        if (req == 2'b11) begin
            win_idx = ptr_reg;
        end
        win_onehot = win_idx ? 2'b10 : 2'b01;
        opnd_sel   = win_idx ? opnd1 : opnd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        alu_op     = ALU_ADD;
        alu_a      = acc_reg;
        alu_b      = b_reg;
        case (state_reg)
            IDLE: if (|req) state_next = MUL1;
            MUL1: begin
                alu_op     = ALU_MUL;
                alu_a      = a_reg;
                alu_b      = x_reg;
                state_next = ADD1;
            end
            ADD1: state_next = MUL2;
            MUL2: begin
                alu_op     = ALU_MUL;
                alu_b      = x_reg;
                state_next = ADD2;
            end
            ADD2: begin
                alu_b      = c_reg;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    poly_alu #(.WIDTH(WIDTH)) u_alu (
        .opa (alu_a),
        .opb (alu_b),
        .op  (alu_op),
        .y   (alu_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_reg  <= '0;
            ptr_reg    <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            x_reg      <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (|req) begin
                    grant_reg <= win_onehot;
                    ptr_reg   <= ~win_idx;
                    a_reg     <= opnd_sel[FIELD_A*WIDTH +: WIDTH];
                    b_reg     <= opnd_sel[FIELD_B*WIDTH +: WIDTH];
                    c_reg     <= opnd_sel[FIELD_C*WIDTH +: WIDTH];
                    x_reg     <= opnd_sel[FIELD_X*WIDTH +: WIDTH];
                end
                MUL1, ADD1, MUL2: acc_reg <= alu_y;
                ADD2:    result_reg <= alu_y;
                DONE:    grant_reg  <= '0;
                default: ;
            endcase
        end
    end

    assign grant  = grant_reg;
    assign busy   = (state_reg != IDLE);
    assign result = result_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_done
        assign done[gi] = (state_reg == DONE) && grant_reg[gi];
    end

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Directed and randomized checks of the shared polynomial engine against a
// transaction-level model (plain polynomial arithmetic, alternating preference).
module tb_poly_eval_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] opnd0, opnd1;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  done;
    logic [7:0]  result;

    int vecs = 0;
    int errs = 0;
    int pref = 0;
    logic [7:0] last_result = 8'h00;

    always #5 clk = ~clk;

    poly_eval_arbiter #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .opnd0  (opnd0),
        .opnd1  (opnd1),
        .grant  (grant),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    function automatic logic [7:0] poly(input logic [31:0] o);
        int a, b, c, x, v;
        a = int'(o[31:24]);
        b = int'(o[23:16]);
        c = int'(o[15:8]);
        x = int'(o[7:0]);
        v = (a * x * x + b * x + c) % 256;
        return v[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic apply_reset();
        reset = 1'b1;
        req   = 2'b00;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        @(negedge clk);
        check("rst_hold_done", 32'(done), 32'h0);
        reset = 1'b0;
        pref = 0;
        last_result = 8'h00;
        @(negedge clk);
    endtask

    task automatic eval(input logic [1:0] r, input logic [31:0] o0, input logic [31:0] o1,
                        input bit perturb, input bit drop);
        int w;
        logic [7:0] exp;
        req   = r;
        opnd0 = o0;
        opnd1 = o1;
        if (r == 2'b11) w = pref;
        else if (r[1])  w = 1;
        else            w = 0;
        pref = 1 - w;
        exp  = poly(w == 1 ? o1 : o0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("grant_c%0d", k), 32'(grant), 32'(2'b01 << w));
            check($sformatf("busy_c%0d", k), 32'(busy), 32'h1);
            if (k < 5) begin
                check($sformatf("done_c%0d", k), 32'(done), 32'h0);
                check($sformatf("result_hold_c%0d", k), 32'(result), 32'(last_result));
            end else begin
                check("done_pulse", 32'(done), 32'(2'b01 << w));
                check("result", 32'(result), 32'(exp));
            end
            if (perturb && k < 4) begin
                opnd0 = $urandom;
                opnd1 = $urandom;
            end
            if (drop && k == 2) req[w] = 1'b0;
        end
        last_result = exp;
        $display("eval req=%b win=%0d opnd=%h result=%h", r, w, (w == 1 ? o1 : o0), result);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_done", 32'(done), 32'h0);
        check("idle_result", 32'(result), 32'(exp));
    endtask

    initial begin
        req   = 2'b00;
        opnd0 = '0;
        opnd1 = '0;
        reset = 1'b0;
        @(negedge clk);
        apply_reset();

        // basic and wrap-around
        eval(2'b01, 32'h02030405, 32'h0, 1'b0, 1'b0);
        eval(2'b01, 32'h10000104, 32'h0, 1'b0, 1'b0);
        eval(2'b01, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);

        // contention from reset: strict alternation starting at requester 0
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            eval(2'b11, 32'h02030405, 32'h01010103, 1'b0, 1'b0);
        end

        // requester 1 drops req during ADD1
        eval(2'b10, 32'h02030405, 32'h01010103, 1'b0, 1'b1);

        // operands change after the grant edge
        eval(2'b01, 32'h02030405, 32'h01010103, 1'b1, 1'b0);

        // reset during MUL2 after requester 0 was granted (pointer would have moved to 1)
        req   = 2'b01;
        opnd0 = 32'h02030405;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("pre_rst_done", 32'(done), 32'h0);
        end
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({busy, done}), 32'h0);
        end
        eval(2'b10, 32'h02030405, 32'h01010103, 1'b0, 1'b0);
        apply_reset();
        eval(2'b11, 32'h02030405, 32'h01010103, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            eval(2'($urandom_range(1, 3)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
